// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALUOp / ALUControl codes and datapath mux selects.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALU operation.
module aludec
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUCTL_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) can encode sub; addi with bit30 set stays add.
          3'b000:  alu_control = (op5 & funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control = ALUCTL_SLT;
          3'b110:  alu_control = ALUCTL_OR;
          3'b111:  alu_control = ALUCTL_AND;
          default: alu_control = ALUCTL_ADD;
        endcase
      end
      default: alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RV32 subset datapath
// (lw, sw, R-type, I-type ALU, jal, beq).
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [3:0] State
);

  state_t     state_reg;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:  state_reg <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_R:         state_reg <= S_EXECR;
            OP_I:         state_reg <= S_EXECI;
            OP_JAL:       state_reg <= S_JAL;
            OP_BEQ:       state_reg <= S_BEQ;
            default:      state_reg <= S_FETCH;
          endcase
        end
        S_MEMADR:  state_reg <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: state_reg <= S_MEMWB;
        S_EXECR, S_EXECI, S_JAL: state_reg <= S_ALUWB;
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_reg <= S_FETCH;
        default:   state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    AdrSrc    = ADR_PC;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    branch    = 1'b0;
    pc_update = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = ADR_ALUOUT;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = ADR_ALUOUT;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  // Strobes are gated by rst_n so they drop the instant reset is asserted.
  assign PCWrite  = rst_n & ((branch & Zero) | pc_update);
  assign IRWrite  = rst_n & ir_write;
  assign RegWrite = rst_n & reg_write;
  assign MemWrite = rst_n & mem_write;
  assign State    = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a
// per-instruction state-sequence and output-table reference model.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] aluc;
    logic       regw;
    logic [1:0] imm;
  } outs_t;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal
  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int k);
    case (k)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1101111;
      5: return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the per-state table.
  function automatic outs_t model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z);
    outs_t e;
    int    aluop;
    bit    branch, pcupd;
    e = '0;
    e.st = 4'(s);
    aluop = 0; branch = 0; pcupd = 0;
    case (s)
      0:  begin e.irw = 1; e.sb = 2; e.res = 2; pcupd = 1; end
      1:  begin e.sa = 1; e.sb = 1; end
      2:  begin e.sa = 2; e.sb = 1; end
      3:  e.adr = 1;
      4:  begin e.res = 1; e.regw = 1; end
      5:  begin e.adr = 1; e.memw = 1; end
      6:  begin e.sa = 2; aluop = 2; end
      7:  e.regw = 1;
      8:  begin e.sa = 2; e.sb = 1; aluop = 2; end
      9:  begin e.sa = 1; e.sb = 2; pcupd = 1; end
      10: begin e.sa = 2; aluop = 1; branch = 1; end
      default: ;
    endcase
    e.pcw = (branch && z) || pcupd;
    if (aluop == 1) e.aluc = 3'b001;
    else if (aluop == 2) begin
      case (f3)
        3'b000:  e.aluc = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010:  e.aluc = 3'b101;
        3'b110:  e.aluc = 3'b011;
        3'b111:  e.aluc = 3'b010;
        default: e.aluc = 3'b000;
      endcase
    end
    case (kind_of(o))
      1: e.imm = 2'b01;
      5: e.imm = 2'b10;
      4: e.imm = 2'b11;
      default: e.imm = 2'b00;
    endcase
    return e;
  endfunction

  task automatic check_outs(input string pfx, input outs_t e);
    check_val({pfx, ".State"},      State,      e.st);
    check_val({pfx, ".PCWrite"},    PCWrite,    e.pcw);
    check_val({pfx, ".AdrSrc"},     AdrSrc,     e.adr);
    check_val({pfx, ".MemWrite"},   MemWrite,   e.memw);
    check_val({pfx, ".IRWrite"},    IRWrite,    e.irw);
    check_val({pfx, ".ResultSrc"},  ResultSrc,  e.res);
    check_val({pfx, ".ALUSrcA"},    ALUSrcA,    e.sa);
    check_val({pfx, ".ALUSrcB"},    ALUSrcB,    e.sb);
    check_val({pfx, ".ALUControl"}, ALUControl, e.aluc);
    check_val({pfx, ".RegWrite"},   RegWrite,   e.regw);
    check_val({pfx, ".ImmSrc"},     ImmSrc,     e.imm);
  endtask

  // Entered at negedge+1 of a FETCH cycle; returns at negedge+1 of the next FETCH.
  // zmode: 0/1 fixed Zero, 2 random Zero every cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    int seq[$];
    int k;
    op = o; funct3 = f3; funct7b5 = f7;
    k = kind_of(o);
    case (k)
      0: seq = '{0, 1, 2, 3, 4};
      1: seq = '{0, 1, 2, 5};
      2: seq = '{0, 1, 6, 7};
      3: seq = '{0, 1, 8, 7};
      4: seq = '{0, 1, 9, 7};
      5: seq = '{0, 1, 10};
      default: seq = '{0, 1};
    endcase
    for (int c = 0; c < seq.size(); c++) begin
      if (c > 0) @(negedge clk);
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check_outs($sformatf("k%0d.c%0d", k, c), model(seq[c], o, f3, f7, Zero));
    end
    @(negedge clk);
    #1;
    check_val("next_fetch", State, 0);
    $display("instr op=%b f3=%b f7b5=%b kind=%0d cycles=%0d", o, f3, f7, k, seq.size());
  endtask

  task automatic check_reset_outs(input string pfx);
    outs_t e;
    e = model(0, op, funct3, funct7b5, Zero);
    e.pcw = 0; e.irw = 0; e.regw = 0; e.memw = 0;
    check_outs(pfx, e);
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    check_reset_outs("reset");
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed scenarios
    run_instr(7'b0000011, 3'b010, 1'b0, 2);  // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 2);  // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 2);  // sub
    run_instr(7'b0110011, 3'b000, 1'b0, 2);  // add
    run_instr(7'b0110011, 3'b111, 1'b0, 2);  // and
    run_instr(7'b0010011, 3'b000, 1'b1, 2);  // addi, bit30 set
    run_instr(7'b1100011, 3'b000, 1'b0, 1);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0);  // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1);  // jal, Zero ignored
    run_instr(7'b1111111, 3'b000, 1'b0, 1);  // illegal

    // Reset asserted mid-MEMREAD
    op = 7'b0000011; funct3 = 3'b010; Zero = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    check_val("pre_reset.State", State, 3);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outs("async_reset");
    @(posedge clk); #1;
    check_reset_outs("held_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #1;
    $display("reset mid-MEMREAD applied and released");

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      int k;
      k = $urandom_range(0, 6);
      o = op_of(k);
      if (k == 6) begin
        o = 7'($urandom);
        if (kind_of(o) != 6) o = 7'b1111111;
      end
      run_instr(o, 3'($urandom), 1'($urandom), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
